ins_fetch: RTL and testbench

//  Instruction fetch stage. Holds the PC and requests one instruction at a time

---
 rtl/ins_fetch.sv | 116 +++++++++++
 tb/tb_ins_fetch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch.sv
// Instruction fetch stage: one outstanding ICache request at a time, static
// JAL-taken prediction, and a small circular queue feeding the decoder.
module ins_fetch #(
  parameter int          IQ_DEPTH = 4,
  parameter int          IQ_AW    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  input  logic        hit,
  input  logic [31:0] hit_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pred_pc,
  input  logic        rob_clear,
  input  logic [31:0] clear_pc
);

  typedef enum logic {S_GAP, S_WAIT} state_t;

  localparam logic [IQ_AW:0] DEPTH_C = (IQ_AW+1)'(IQ_DEPTH);

  state_t           state_q, state_d;
  logic             fetchValid_q;
  logic [31:0]      pc_q, pc_d;
  logic [IQ_AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [IQ_AW:0]   count_q, count_d;

  logic [31:0] instBuf_q [IQ_DEPTH];
  logic [31:0] pcBuf_q   [IQ_DEPTH];
  logic [31:0] predBuf_q [IQ_DEPTH];

  logic        isJal, push, pop, wrEn;
  logic [31:0] jalImm, predPc;

  assign isJal  = (hit_inst[6:0] == 7'b1101111);
  assign jalImm = {{11{hit_inst[31]}}, hit_inst[31], hit_inst[19:12],
                   hit_inst[20], hit_inst[30:21], 1'b0};
  assign predPc = pc_q + (isJal ? jalImm : 32'd4);

  assign push = (state_q == S_WAIT) && hit;
  assign pop  = out_valid && out_ready;
  assign wrEn = rdy_in && push && !rob_clear;

  // A flush wins over any push or pop arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rob_clear) begin
      state_d = S_GAP;
      pc_d    = clear_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      case (state_q)
        S_GAP:  if (count_q < DEPTH_C) state_d = S_WAIT;
        S_WAIT: if (hit) begin
          state_d = S_GAP;
          pc_d    = predPc;
        end
        default: state_d = S_GAP;
      endcase
      if (push) tail_d = tail_q + IQ_AW'(1);
      if (pop)  head_d = head_q + IQ_AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (IQ_AW+1)'(1);
        2'b01:   count_d = count_q - (IQ_AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_GAP;
      fetchValid_q <= 1'b0;
      pc_q         <= RESET_PC;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      fetchValid_q <= (state_d == S_WAIT);
      pc_q         <= pc_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
    end
  end

  // Queue storage needs no reset; count_q alone decides what is valid.
  always_ff @(posedge clk_in) begin
    if (wrEn) begin
      instBuf_q[tail_q] <= hit_inst;
      pcBuf_q[tail_q]   <= pc_q;
      predBuf_q[tail_q] <= predPc;
    end
  end

  assign fetch_valid = fetchValid_q;
  assign fetch_pc    = pc_q;
  assign out_valid   = (count_q != '0);
  assign out_inst    = instBuf_q[head_q];
  assign out_pc      = pcBuf_q[head_q];
  assign out_pred_pc = predBuf_q[head_q];

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: a scoreboard queue of expected instructions is
// filled as hits are issued and drained by a monitor on every decoder handshake.
module tb_ins_fetch;

  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] JAL_POS = 32'h020000EF;
  localparam logic [31:0] JAL_NEG = 32'hFF9FF0EF;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, hit, out_ready, rob_clear;
  logic [31:0] hit_inst, clear_pc;
  logic        fetch_valid, out_valid;
  logic [31:0] fetch_pc, out_inst, out_pc, out_pred_pc;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred;
  } exp_t;

  exp_t sb[$];
  exp_t monExp;
  int   errors = 0;
  int   checks = 0;

  ins_fetch #(.IQ_DEPTH(4), .IQ_AW(2), .RESET_PC(32'h0)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .hit         (hit),
    .hit_inst    (hit_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_pred_pc (out_pred_pc),
    .rob_clear   (rob_clear),
    .clear_pc    (clear_pc)
  );

  always #5 clk_in = ~clk_in;

  // Monitor: every accepted head must match the oldest expected entry.
  always @(negedge clk_in) begin
    if (!rst_in && rdy_in && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_pop: got pc=0x%08h inst=0x%08h, expected no entry",
                 out_pc, out_inst);
      end else begin
        monExp = sb.pop_front();
        if ({out_inst, out_pc, out_pred_pc} !== monExp) begin
          errors++;
          $display("[TB] FAIL head: got inst=0x%08h pc=0x%08h pred=0x%08h, expected inst=0x%08h pc=0x%08h pred=0x%08h",
                   out_inst, out_pc, out_pred_pc, monExp.inst, monExp.pc, monExp.pred);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    rst_in = 1'b1;
    hit    = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    sb.delete();
  endtask

  task automatic waitFetch();
    bit found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (fetch_valid) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL fetch_timeout: got fetch_valid=0 for 60 cycles, expected 1");
    end
  endtask

  task automatic waitEmpty();
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (sb.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d entries pending, expected 0", sb.size());
    end
  endtask

  // Plays the ICache: one cycle to sample the request, missCycles of miss,
  // then a single-cycle hit carrying the given word.
  task automatic applyStimulus(input logic [31:0] expPc, input logic [31:0] word,
                               input logic [31:0] expPred, input int missCycles);
    waitFetch();
    checkOutput("fetch_pc", fetch_pc, expPc);
    @(posedge clk_in); #1;
    for (int i = 0; i < missCycles; i++) begin
      hit = 1'b0;
      @(negedge clk_in);
      checkOutput("miss_fetch_valid", {31'b0, fetch_valid}, 32'd1);
      checkOutput("miss_fetch_pc", fetch_pc, expPc);
      @(posedge clk_in); #1;
    end
    hit      = 1'b1;
    hit_inst = word;
    sb.push_back('{inst: word, pc: expPc, pred: expPred});
    @(posedge clk_in); #1;
    hit      = 1'b0;
    hit_inst = 32'h0;
    @(negedge clk_in);
    checkOutput("gap_after_hit", {31'b0, fetch_valid}, 32'd0);
  endtask

  task automatic doClear(input logic [31:0] target);
    waitEmpty();
    @(posedge clk_in); #1;
    rob_clear = 1'b1;
    clear_pc  = target;
    @(posedge clk_in); #1;
    rob_clear = 1'b0;
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish by 100us, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    hit       = 1'b0;
    hit_inst  = 32'h0;
    out_ready = 1'b1;
    rob_clear = 1'b0;
    clear_pc  = 32'h0;

    // Reset state and straight-line NOP fetches.
    resetDut();
    @(negedge clk_in);
    checkOutput("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_fetch_pc", fetch_pc, 32'h0);
    applyStimulus(32'h0, NOP, 32'h4, 0);
    applyStimulus(32'h4, NOP, 32'h8, 0);
    applyStimulus(32'h8, NOP, 32'hC, 0);

    // JAL prediction, forward and backward.
    applyStimulus(32'hC,  NOP,     32'h10, 0);
    applyStimulus(32'h10, JAL_POS, 32'h30, 0);
    applyStimulus(32'h30, NOP,     32'h34, 0);
    doClear(32'h10);
    applyStimulus(32'h10, JAL_NEG, 32'h08, 0);
    applyStimulus(32'h08, NOP,     32'h0C, 0);
    waitEmpty();

    // Fill the queue with the decoder stalled, then drain and resume.
    resetDut();
    out_ready = 1'b0;
    applyStimulus(32'h0, NOP, 32'h4, 0);
    applyStimulus(32'h4, NOP, 32'h8, 0);
    applyStimulus(32'h8, NOP, 32'hC, 0);
    applyStimulus(32'hC, NOP, 32'h10, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      checkOutput("full_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    end
    checkOutput("full_out_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk_in); #1;
    out_ready = 1'b1;
    applyStimulus(32'h10, NOP, 32'h14, 0);

    // Long miss: request held stable, single enqueue on the hit.
    applyStimulus(32'h14, NOP, 32'h18, 10);
    waitEmpty();

    // Flush colliding with a hit while two entries are queued.
    @(posedge clk_in); #1;
    out_ready = 1'b0;
    applyStimulus(32'h18, NOP, 32'h1C, 0);
    applyStimulus(32'h1C, NOP, 32'h20, 0);
    waitFetch();
    checkOutput("pre_clear_pc", fetch_pc, 32'h20);
    @(posedge clk_in); #1;
    hit       = 1'b1;
    hit_inst  = NOP;
    rob_clear = 1'b1;
    clear_pc  = 32'h100;
    @(posedge clk_in); #1;
    hit       = 1'b0;
    rob_clear = 1'b0;
    sb.delete();
    @(negedge clk_in);
    checkOutput("clear_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("clear_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    checkOutput("clear_fetch_pc", fetch_pc, 32'h100);
    @(posedge clk_in); #1;
    out_ready = 1'b1;
    applyStimulus(32'h100, NOP, 32'h104, 0);

    // Freeze with a hit pending; the push must happen exactly once afterwards.
    waitFetch();
    checkOutput("pre_freeze_pc", fetch_pc, 32'h104);
    @(posedge clk_in); #1;
    rdy_in   = 1'b0;
    hit      = 1'b1;
    hit_inst = NOP;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      checkOutput("freeze_fetch_valid", {31'b0, fetch_valid}, 32'd1);
      checkOutput("freeze_fetch_pc", fetch_pc, 32'h104);
      checkOutput("freeze_out_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk_in); #1;
    end
    rdy_in = 1'b1;
    sb.push_back('{inst: NOP, pc: 32'h104, pred: 32'h108});
    @(posedge clk_in); #1;
    hit = 1'b0;
    @(negedge clk_in);
    checkOutput("thaw_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    checkOutput("thaw_fetch_pc", fetch_pc, 32'h108);
    waitEmpty();

    // Reset in the middle of an outstanding request.
    waitFetch();
    checkOutput("pre_reset_pc", fetch_pc, 32'h108);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    sb.delete();
    @(negedge clk_in);
    checkOutput("midrst_fetch_pc", fetch_pc, 32'h0);
    checkOutput("midrst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);

    repeat (3) @(negedge clk_in);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
